// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - MIPS HI/LO multiply/divide unit
// Iterative shift-add multiplier and restoring divider, one operand bit per cycle.
package mips_pkg;
  typedef logic [5:0] funct_t;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;
  localparam funct_t FUNCT_ADD   = 6'h20;
endpackage

module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  mips_pkg::funct_t      funct,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  import mips_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          state, state_nxt;
  logic [2*W:0]    acc;
  logic [2*W:0]    acc_nxt;
  logic [W-1:0]    opb;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, dbz_q;

  logic            accept, is_mul, is_div, is_signed, rt_zero, last;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, div_shift, div_rem;
  logic            div_ge;
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    quot, rem, quot_fix, rem_fix;

  assign accept    = start && (state == S_IDLE || state == S_FIN);
  assign is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign rt_zero   = (rt_data == '0);
  assign last      = (cnt == CW'(W - 1));

  assign a_neg = is_signed && rs_data[W-1];
  assign b_neg = is_signed && rt_data[W-1];
  assign a_mag = a_neg ? -rs_data : rs_data;
  assign b_mag = b_neg ? -rt_data : rt_data;

  // acc holds {partial/remainder (W+1), multiplier/quotient (W)} for both ops
  assign mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_rem   = div_ge ? (div_shift - {1'b0, opb}) : div_shift;
  assign acc_nxt   = (state == S_MUL) ? {1'b0, mul_sum, acc[W-1:1]}
                                      : {div_rem, acc[W-2:0], div_ge};

  assign prod     = acc_nxt[2*W-1:0];
  assign prod_fix = neg_q ? -prod : prod;
  assign quot     = acc_nxt[W-1:0];
  assign rem      = acc_nxt[2*W-1:W];
  assign quot_fix = neg_q ? -quot : quot;
  assign rem_fix  = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FIN: begin
        state_nxt = S_IDLE;
        if (start && is_mul)      state_nxt = S_MUL;
        else if (start && is_div) state_nxt = rt_zero ? S_FIN : S_DIV;
      end
      S_MUL, S_DIV: if (last) state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_MUL) || (state == S_DIV);
    done        = (state == S_FIN);
    div_by_zero = (state == S_FIN) && dbz_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opb   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      if (is_mul || is_div) begin
        acc   <= {{(W+1){1'b0}}, a_mag};
        opb   <= b_mag;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dbz_q <= is_div && rt_zero;
      end else if (funct == FUNCT_MTHI) begin
        hi <= rs_data;
      end else if (funct == FUNCT_MTLO) begin
        lo <= rs_data;
      end
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      // Final iteration writes the sign-corrected result in the same edge
      if (last && state == S_MUL) begin
        hi <= prod_fix[2*W-1:W];
        lo <= prod_fix[W-1:0];
      end else if (last) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit
// Directed cases plus randomized ops against an arithmetic HI/LO model.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  funct_t      funct;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit completes(input funct_t f);
    return f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU;
  endfunction

  task automatic model(input funct_t f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    m_dbz = 1'b0;
    case (f)
      FUNCT_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      FUNCT_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      FUNCT_DIV: begin
        if (b == 0) m_dbz = 1'b1;
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      FUNCT_DIVU: begin
        if (b == 0) m_dbz = 1'b1;
        else begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      end
      FUNCT_MTHI: m_hi = a;
      FUNCT_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_done(output int lat, output int bcy);
    lat = 0;
    bcy = 0;
    while (!done && lat < 100) begin
      if (busy) bcy++;
      @(negedge clk);
      lat++;
    end
    if (!done) check_eq("done_timeout", done, 1);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after edge 0)
  task automatic run_op(input funct_t f, input logic [31:0] a, input logic [31:0] b);
    int lat, bcy;
    model(f, a, b);
    start = 1'b1; funct = f; rs_data = a; rt_data = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (completes(f)) begin
      wait_done(lat, bcy);
      check_eq($sformatf("latency f=%h", f), lat, m_dbz ? 0 : 32);
      check_eq($sformatf("busy_cycles f=%h", f), bcy, m_dbz ? 0 : 32);
      check_eq($sformatf("dbz f=%h", f), div_by_zero, m_dbz);
      check_eq($sformatf("hi f=%h a=%h b=%h", f, a, b), hi, m_hi);
      check_eq($sformatf("lo f=%h a=%h b=%h", f, a, b), lo, m_lo);
    end else begin
      check_eq($sformatf("nobusy f=%h", f), busy, 0);
      check_eq($sformatf("nodone f=%h", f), done, 0);
      check_eq($sformatf("hi f=%h", f), hi, m_hi);
      check_eq($sformatf("lo f=%h", f), lo, m_lo);
    end
  endtask

  funct_t ops[7] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO, FUNCT_ADD};

  initial begin
    int lat, bcy;
    logic [31:0] a, b;
    funct_t f;
    rst = 1'b1; start = 1'b0; funct = FUNCT_ADD; rs_data = '0; rt_data = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(FUNCT_MULT, 32'hFFFFFFFE, 32'h3);
    check_eq("mult_hi_lit", hi, 32'hFFFFFFFF);
    check_eq("mult_lo_lit", lo, 32'hFFFFFFFA);
    @(negedge clk);
    check_eq("mult_done_once", done, 0);

    run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("multu_hi_lit", hi, 32'hFFFFFFFE);
    check_eq("multu_lo_lit", lo, 32'h00000001);
    @(negedge clk);
    check_eq("multu_done_once", done, 0);

    run_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
    check_eq("div_lo_lit", lo, 32'hFFFFFFFD);
    check_eq("div_hi_lit", hi, 32'hFFFFFFFF);
    run_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    check_eq("divmin_lo_lit", lo, 32'h80000000);
    check_eq("divmin_hi_lit", hi, 32'h0);
    @(negedge clk);

    run_op(FUNCT_MTHI, 32'hAA, 32'h0);
    run_op(FUNCT_MTLO, 32'hBB, 32'h0);
    run_op(FUNCT_DIVU, 32'd100, 32'd0);
    check_eq("dbz_lit", div_by_zero, 1);
    check_eq("dbz_hi_lit", hi, 32'hAA);
    check_eq("dbz_lo_lit", lo, 32'hBB);
    @(negedge clk);
    check_eq("dbz_done_once", done, 0);

    run_op(FUNCT_ADD, 32'h55, 32'h66);
    run_op(FUNCT_MTLO, 32'h1234, 32'h0);
    check_eq("mtlo_lit", lo, 32'h1234);

    // DIVU issued mid-multiply must be dropped
    model(FUNCT_MULTU, 32'd7, 32'd9);
    start = 1'b1; funct = FUNCT_MULTU; rs_data = 32'd7; rt_data = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; funct = FUNCT_DIVU; rs_data = 32'd5; rt_data = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcy);
    check_eq("intrude_latency", lat, 28);
    check_eq("intrude_hi", hi, m_hi);
    check_eq("intrude_lo", lo, m_lo);
    @(negedge clk);
    check_eq("intrude_no_busy", busy, 0);
    check_eq("intrude_no_done", done, 0);

    // Reset in the middle of a MULT
    start = 1'b1; funct = FUNCT_MULT; rs_data = 32'h1234567; rt_data = 32'h89ABCDE;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_hi", hi, 0);
    check_eq("midrst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check_eq("postrst_busy", busy, 0);
    check_eq("postrst_done", done, 0);
    run_op(FUNCT_MULTU, 32'd3, 32'd4);
    check_eq("postrst_lo_lit", lo, 32'd12);
    check_eq("postrst_hi_lit", hi, 32'd0);

    for (int i = 0; i < 60; i++) begin
      f = ops[$urandom_range(0, 6)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_op(f, a, b);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
